// File: rtl/piano_pkg.sv
// -----------------------------------------------------------------------------
// piano_pkg
// Shared constants for the piano volume path: envelope FSM state encodings,
// the width of the volume_control code and default envelope timing/levels.
// Also carries a small helper used to compute the effective sustain level.
// -----------------------------------------------------------------------------
package piano_pkg;

    // Width of the volume_control `control` code.
    localparam int VOL_W = 3;

    // Envelope FSM state encodings (kept as plain 3-bit constants so the
    // debug port matches older tooling that decodes env_state numerically).
    localparam logic [2:0] ENV_IDLE    = 3'd0;
    localparam logic [2:0] ENV_ATTACK  = 3'd1;
    localparam logic [2:0] ENV_DECAY   = 3'd2;
    localparam logic [2:0] ENV_SUSTAIN = 3'd3;
    localparam logic [2:0] ENV_RELEASE = 3'd4;

    // Defaults: one envelope step per millisecond at 50 MHz.
    localparam int               DEF_STEP_DIV    = 50000;
    localparam int               DEF_DIV_W       = 16;
    localparam logic [VOL_W-1:0] DEF_SUSTAIN_LVL = 3'd5;

    // Smaller of two volume codes.
    function automatic logic [VOL_W-1:0] vol_min(input logic [VOL_W-1:0] a,
                                                 input logic [VOL_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage : piano_pkg

// File: rtl/volume_envelope_ctrl_if.sv
// -----------------------------------------------------------------------------
// volume_envelope_ctrl_if
// Groups the key-side inputs and the volume/debug outputs of the envelope
// controller.
//   gate       : key held (driven by key/gate logic)
//   peak_lvl   : attack target level, used on gate rising edge
//   vol_ctrl   : volume code towards volume_control `control`
//   env_active : envelope running (state != IDLE)
//   env_state  : current FSM state, debug only
// modport master : the key/gate side (drives gate/peak_lvl)
// modport slave  : the envelope controller
// -----------------------------------------------------------------------------
interface volume_envelope_ctrl_if;
    import piano_pkg::*;

    logic             gate;
    logic [VOL_W-1:0] peak_lvl;
    logic [VOL_W-1:0] vol_ctrl;
    logic             env_active;
    logic [2:0]       env_state;

    modport master (
        output gate,
        output peak_lvl,
        input  vol_ctrl,
        input  env_active,
        input  env_state
    );

    modport slave (
        input  gate,
        input  peak_lvl,
        output vol_ctrl,
        output env_active,
        output env_state
    );

endinterface : volume_envelope_ctrl_if

// File: rtl/volume_envelope_ctrl_prescaler.sv
// -----------------------------------------------------------------------------
// env_prescaler
// Envelope step prescaler: counts 0..STEP_DIV-1 while enabled and pulses
// tick for one cycle on the last count, wrapping to 0.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clr   : forces the count back to 0 on the next edge (phase change)
//   en    : count enable; the count is held at 0 while low
//   tick  : high during the cycle the count equals STEP_DIV-1 (and en high)
// -----------------------------------------------------------------------------
module env_prescaler #(
    parameter int STEP_DIV = 50000,
    parameter int DIV_W    = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(STEP_DIV - 1);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;

    assign tick = en & (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clr || !en) begin
            count_d = '0;
        end else if (tick) begin
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : env_prescaler

// File: rtl/volume_envelope_ctrl.sv
// -----------------------------------------------------------------------------
// volume_envelope_ctrl
// ADSR-style envelope sequencer for the volume_control `control` input. Each
// gate rise starts an attack up to the latched peak level, decays to the
// effective sustain level, holds while the key is down, and releases to 0
// after the gate falls. One level step per prescaler tick.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of volume_envelope_ctrl_if (gate, peak_lvl in;
//           vol_ctrl, env_active, env_state out)
// Optional build macro: VOLENV_RETRIGGER_EN -- a gate rise during RELEASE
// re-enters ATTACK (or DECAY) from the current level instead of being ignored.
// -----------------------------------------------------------------------------
module volume_envelope_ctrl
    import piano_pkg::*;
#(
    parameter int               STEP_DIV    = DEF_STEP_DIV,
    parameter int               DIV_W       = DEF_DIV_W,
    parameter logic [VOL_W-1:0] SUSTAIN_LVL = DEF_SUSTAIN_LVL
) (
    input  logic                   clk,
    input  logic                   rst_n,
    volume_envelope_ctrl_if.slave  bus
);

    localparam logic [VOL_W-1:0] VOL_MAX = '1;

    logic [2:0]       state_q, state_d;
    logic [VOL_W-1:0] vol_q,   vol_d;
    logic [VOL_W-1:0] peak_q,  peak_d;
    logic             gate_q,  gate_d;

    logic             rise, fall;
    logic             tick;
    logic             presc_en;
    logic             presc_clr;
    logic [VOL_W-1:0] sus_eff;

    // Edges come from one registered sample, so rise and fall are exclusive.
    assign rise    = bus.gate & ~gate_q;
    assign fall    = ~bus.gate & gate_q;
    assign gate_d  = bus.gate;
    assign sus_eff = vol_min(SUSTAIN_LVL, peak_q);

    assign presc_en  = (state_q == ENV_ATTACK) || (state_q == ENV_DECAY) ||
                       (state_q == ENV_RELEASE);
    // Restart the step timer on every phase change so each phase's first step
    // lands exactly STEP_DIV cycles after entry.
    assign presc_clr = (state_d != state_q);

    env_prescaler #(
        .STEP_DIV (STEP_DIV),
        .DIV_W    (DIV_W)
    ) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (presc_clr),
        .en    (presc_en),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        vol_d   = vol_q;
        peak_d  = peak_q;
        case (state_q)
            ENV_IDLE: begin
                if (rise) begin
                    peak_d  = bus.peak_lvl;
                    vol_d   = '0;
                    state_d = ENV_ATTACK;
                end
            end
            ENV_ATTACK: begin
                // Fall wins over a coincident tick; level is held this cycle.
                if (fall) begin
                    state_d = ENV_RELEASE;
                end else if (vol_q >= peak_q) begin
                    state_d = ENV_DECAY;
                end else if (tick && vol_q != VOL_MAX) begin
                    vol_d = vol_q + 1'b1;
                end
            end
            ENV_DECAY: begin
                if (fall) begin
                    state_d = ENV_RELEASE;
                end else if (vol_q <= sus_eff) begin
                    state_d = ENV_SUSTAIN;
                end else if (tick) begin
                    vol_d = vol_q - 1'b1;
                end
            end
            ENV_SUSTAIN: begin
                if (fall) begin
                    state_d = ENV_RELEASE;
                end
            end
            ENV_RELEASE: begin
`ifdef VOLENV_RETRIGGER_EN
                // Legato retrigger: keep the current level to avoid a click.
                if (rise) begin
                    peak_d  = bus.peak_lvl;
                    state_d = (vol_q >= bus.peak_lvl) ? ENV_DECAY : ENV_ATTACK;
                end else
`endif
                if (vol_q == '0) begin
                    state_d = ENV_IDLE;
                end else if (tick) begin
                    vol_d = vol_q - 1'b1;
                end
            end
            default: begin
                state_d = ENV_IDLE;
                vol_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ENV_IDLE;
            vol_q   <= '0;
            peak_q  <= '0;
            gate_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vol_q   <= vol_d;
            peak_q  <= peak_d;
            gate_q  <= gate_d;
        end
    end

    assign bus.vol_ctrl   = vol_q;
    assign bus.env_active = (state_q != ENV_IDLE);
    assign bus.env_state  = state_q;

endmodule : volume_envelope_ctrl

// File: tb/tb_volume_envelope_ctrl.sv
// -----------------------------------------------------------------------------
// tb_volume_envelope_ctrl
// Directed bench for volume_envelope_ctrl with STEP_DIV=4, SUSTAIN_LVL=5.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_volume_envelope_ctrl;
    import piano_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vec  = 0;
    int   errs = 0;

    volume_envelope_ctrl_if bus ();

    volume_envelope_ctrl #(
        .STEP_DIV    (4),
        .DIV_W       (16),
        .SUSTAIN_LVL (3'd5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vec++;
        $display("vec %0d %s observed=%0d expected=%0d", vec, tag, obs, exp);
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_sv(input string tag, input int st, input int v);
        chk({tag, "_state"}, int'(bus.env_state), st);
        chk({tag, "_vol"},   int'(bus.vol_ctrl),  v);
    endtask

    // Bounded wait for IDLE; an expired budget is recorded as a miscompare.
    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (bus.env_state !== ENV_IDLE && n < budget) begin
            step(1);
            n++;
        end
        chk({tag, "_reached_idle"}, int'(bus.env_state === ENV_IDLE), 1);
    endtask

    initial begin
        bus.gate     = 1'b0;
        bus.peak_lvl = 3'd0;
        #2;
        // Reset state
        chk("rst_vol", int'(bus.vol_ctrl), 0);
        chk("rst_active", int'(bus.env_active), 0);
        chk("rst_state", int'(bus.env_state), 0);
        step(2);
        rst_n = 1'b1;
        step(2);
        chk_sv("idle_no_gate", 0, 0);

        // ---- Full note, peak 7 (peak_lvl changed mid-note is ignored) ----
        bus.peak_lvl = 3'd7;
        bus.gate     = 1'b1;
        step(1);                                  // P1
        chk_sv("fn_enter_attack", 1, 0);
        bus.peak_lvl = 3'd2;
        for (int k = 1; k <= 7; k++) begin
            step(3);
            chk("fn_attack_hold", int'(bus.vol_ctrl), k - 1);
            step(1);                              // P1+4k
            chk("fn_attack_step", int'(bus.vol_ctrl), k);
        end
        step(1);                                  // P30
        chk_sv("fn_decay", 2, 7);
        step(4);
        chk("fn_decay_6", int'(bus.vol_ctrl), 6);
        step(3);
        chk("fn_decay_hold6", int'(bus.vol_ctrl), 6);
        step(1);                                  // P38
        chk("fn_decay_5", int'(bus.vol_ctrl), 5);
        step(1);                                  // P39
        chk_sv("fn_sustain", 3, 5);
        step(61);                                 // P100
        chk_sv("fn_sustain_hold", 3, 5);
        bus.gate = 1'b0;
        step(1);                                  // P101
        chk_sv("fn_release", 4, 5);
        for (int k = 4; k >= 0; k--) begin
            step(3);
            chk("fn_rel_hold", int'(bus.vol_ctrl), k + 1);
            step(1);
            chk("fn_rel_step", int'(bus.vol_ctrl), k);
        end
        step(1);
        chk_sv("fn_idle", 0, 0);
        chk("fn_idle_active", int'(bus.env_active), 0);

        // ---- Early release during ATTACK at level 3 ----
        bus.peak_lvl = 3'd7;
        bus.gate     = 1'b1;
        step(13);                                 // P13: vol 3
        chk_sv("er_attack3", 1, 3);
        bus.gate = 1'b0;
        step(1);
        chk_sv("er_release", 4, 3);
        step(3);
        chk("er_hold3", int'(bus.vol_ctrl), 3);
        step(1);
        chk("er_step2", int'(bus.vol_ctrl), 2);
        wait_idle("er", 20);
        chk("er_final_vol", int'(bus.vol_ctrl), 0);

        // ---- Low peak 2: sustain at min(5,2)=2 ----
        bus.peak_lvl = 3'd2;
        bus.gate     = 1'b1;
        step(9);                                  // P9
        chk_sv("lp_attack2", 1, 2);
        step(1);
        chk_sv("lp_decay", 2, 2);
        step(1);
        chk_sv("lp_sustain", 3, 2);
        step(8);
        chk_sv("lp_sustain_hold", 3, 2);
        bus.gate = 1'b0;
        step(1);
        chk_sv("lp_release", 4, 2);
        wait_idle("lp", 20);

        // ---- Peak 0: level stays 0, envelope active until gate falls ----
        bus.peak_lvl = 3'd0;
        bus.gate     = 1'b1;
        step(1);
        chk_sv("p0_attack", 1, 0);
        step(2);
        chk_sv("p0_sustain", 3, 0);
        step(10);
        chk("p0_active", int'(bus.env_active), 1);
        chk("p0_vol", int'(bus.vol_ctrl), 0);
        bus.gate = 1'b0;
        step(1);
        chk_sv("p0_release", 4, 0);
        step(1);
        chk_sv("p0_idle", 0, 0);

        // ---- Fall coincident with tick in DECAY at level 6 ----
        bus.peak_lvl = 3'd7;
        bus.gate     = 1'b1;
        step(37);                                 // P37: DECAY, vol 6, count 3
        chk_sv("ft_decay6", 2, 6);
        bus.gate = 1'b0;
        step(1);                                  // P38
        chk_sv("ft_release", 4, 6);
        step(4);
        chk("ft_rel5", int'(bus.vol_ctrl), 5);
        wait_idle("ft", 40);

        // ---- Re-press during RELEASE at level 2 ----
        bus.peak_lvl = 3'd7;
        bus.gate     = 1'b1;
        step(39);                                 // P39: SUSTAIN 5
        chk_sv("rp_sustain", 3, 5);
        bus.gate = 1'b0;
        step(13);                                 // P52: RELEASE, vol 2
        chk_sv("rp_release2", 4, 2);
        bus.gate = 1'b1;
        step(1);                                  // P53
`ifdef VOLENV_RETRIGGER_EN
        chk_sv("rp_retrig_attack", 1, 2);
        step(4);
        chk("rp_retrig_3", int'(bus.vol_ctrl), 3);
        step(16);
        chk("rp_retrig_7", int'(bus.vol_ctrl), 7);
        bus.gate = 1'b0;
        step(1);
        wait_idle("rp_retrig", 60);
`else
        chk_sv("rp_ignored", 4, 2);
        step(3);
        chk("rp_rel1", int'(bus.vol_ctrl), 1);
        step(4);
        chk("rp_rel0", int'(bus.vol_ctrl), 0);
        step(1);
        chk_sv("rp_idle", 0, 0);
        step(5);
        chk_sv("rp_idle_gate_high", 0, 0);
        bus.gate = 1'b0;
        step(1);
`endif
        bus.gate = 1'b1;
        step(1);
        chk_sv("rp_new_attack", 1, 0);

        // ---- Async reset mid-SUSTAIN ----
        step(38);                                 // P39 after this rise
        chk_sv("ar_sustain", 3, 5);
        #2;
        rst_n    = 1'b0;
        bus.gate = 1'b0;
        #1;
        chk("ar_vol", int'(bus.vol_ctrl), 0);
        chk("ar_active", int'(bus.env_active), 0);
        chk("ar_state", int'(bus.env_state), 0);
        #1;
        rst_n = 1'b1;
        step(5);
        chk_sv("ar_stay_idle", 0, 0);
        bus.peak_lvl = 3'd3;
        bus.gate     = 1'b1;
        step(1);
        chk_sv("ar_rise_attack", 1, 0);
        step(4);
        chk("ar_attack1", int'(bus.vol_ctrl), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule : tb_volume_envelope_ctrl
